// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS main control and ALU control.
// Holds state encoding, opcode constants, ALUOP classes and the control
// output bundle. Optional macro: MIPS_IMM_ALU_EN (enables addi/andi/ori/slti).
package mips_ctrl_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned ALUOP_W = 6;
  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTEXEC  = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_IMMEXEC = 4'd10,
    S_IMMWB   = 4'd11
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 6'h00;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 6'h01;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 6'h02;
  localparam logic [ALUOP_W-1:0] ALUOP_AND   = 6'h03;
  localparam logic [ALUOP_W-1:0] ALUOP_OR    = 6'h04;
  localparam logic [ALUOP_W-1:0] ALUOP_SLT   = 6'h05;

  typedef struct packed {
    logic               pc_write;
    logic               pc_write_cond;
    logic               i_or_d;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic               mem_to_reg;
    logic               reg_dst;
    logic               reg_write;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [1:0]         pc_source;
    logic [ALUOP_W-1:0] aluop;
    logic               illegal;
    logic               instr_done;
  } ctrl_t;

  // I-type ALU opcodes
  function automatic logic is_imm_op(input logic [OP_W-1:0] op);
    return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) || (op == OP_SLTI);
  endfunction

  // Opcodes the FSM will execute in this build
  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    logic base;
    base = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J);
`ifdef MIPS_IMM_ALU_EN
    return base || is_imm_op(op);
`else
    return base;
`endif
  endfunction

  // ALU class for the I-type execute step
  function automatic logic [ALUOP_W-1:0] imm_aluop(input logic [OP_W-1:0] op);
    case (op)
      OP_ANDI: return ALUOP_AND;
      OP_ORI:  return ALUOP_OR;
      OP_SLTI: return ALUOP_SLT;
      default: return ALUOP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational decoder: state + opcode + mem_ready -> datapath controls.
// Ports: rst_n (forces all controls to 0 while low), state, opcode,
// mem_ready in; ctrl bundle out. Optional macro: MIPS_IMM_ALU_EN.
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  logic              rst_n,
  input  state_t            state,
  input  logic [OP_W-1:0]   opcode,
  input  logic              mem_ready,
  output ctrl_t             ctrl
);

  // Per-state control decode; unlisted fields stay 0
  always_comb begin
    ctrl = '0;
    if (rst_n) begin
      case (state)
        S_FETCH: begin
          ctrl.mem_read  = 1'b1;
          ctrl.alu_src_b = 2'd1;
          ctrl.aluop     = ALUOP_ADD;
          // PC+4 and IR load only commit on the cycle memory returns data
          ctrl.ir_write  = mem_ready;
          ctrl.pc_write  = mem_ready;
        end
        S_DECODE: begin
          ctrl.alu_src_b = 2'd3;
          ctrl.aluop     = ALUOP_ADD;
          ctrl.illegal   = !is_legal_op(opcode);
        end
        S_MEMADR: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = 2'd2;
          ctrl.aluop     = ALUOP_ADD;
        end
        S_MEMRD: begin
          ctrl.i_or_d   = 1'b1;
          ctrl.mem_read = 1'b1;
        end
        S_MEMWB: begin
          ctrl.mem_to_reg = 1'b1;
          ctrl.reg_write  = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        S_MEMWR: begin
          ctrl.i_or_d     = 1'b1;
          ctrl.mem_write  = 1'b1;
          ctrl.instr_done = mem_ready;
        end
        S_RTEXEC: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.aluop     = ALUOP_FUNCT;
        end
        S_ALUWB: begin
          ctrl.reg_dst    = 1'b1;
          ctrl.reg_write  = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        S_BRANCH: begin
          ctrl.alu_src_a     = 1'b1;
          ctrl.aluop         = ALUOP_SUB;
          ctrl.pc_write_cond = 1'b1;
          ctrl.pc_source     = 2'd1;
          ctrl.instr_done    = 1'b1;
        end
        S_JUMP: begin
          ctrl.pc_write   = 1'b1;
          ctrl.pc_source  = 2'd2;
          ctrl.instr_done = 1'b1;
        end
`ifdef MIPS_IMM_ALU_EN
        S_IMMEXEC: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = 2'd2;
          ctrl.aluop     = imm_aluop(opcode);
        end
        S_IMMWB: begin
          ctrl.reg_write  = 1'b1;
          ctrl.instr_done = 1'b1;
        end
`endif
        default: ctrl = '0;
      endcase
    end
  end

endmodule

// File: rtl/mips_main_control.sv
// Multicycle MIPS main control FSM: state register, next-state logic and
// the output decoder instance. Ports: clk, rst_n (sync, active-low),
// opcode, mem_ready in; PC/memory/regfile/ALU controls, ALUOP, illegal,
// instr_done and debug state out. Optional macro: MIPS_IMM_ALU_EN.
module mips_main_control
  import mips_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OP_W-1:0]     opcode,
  input  logic                mem_ready,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                MemtoReg,
  output logic                RegDst,
  output logic                RegWrite,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          PCSource,
  output logic [ALUOP_W-1:0]  ALUOP,
  output logic                illegal,
  output logic                instr_done,
  output logic [STATE_W-1:0]  state
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic; unused codes fall back to FETCH
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTEXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
`ifdef MIPS_IMM_ALU_EN
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IMMEXEC;
`endif
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   if (mem_ready) state_d = S_FETCH;
      S_RTEXEC:  state_d = S_ALUWB;
      S_ALUWB:   state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_JUMP:    state_d = S_FETCH;
`ifdef MIPS_IMM_ALU_EN
      S_IMMEXEC: state_d = S_IMMWB;
      S_IMMWB:   state_d = S_FETCH;
`endif
      default:   state_d = S_FETCH;
    endcase
  end

  mips_ctrl_outdec u_outdec (
    .rst_n     (rst_n),
    .state     (state_q),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.i_or_d;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign RegDst      = ctrl.reg_dst;
  assign RegWrite    = ctrl.reg_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign PCSource    = ctrl.pc_source;
  assign ALUOP       = ctrl.aluop;
  assign illegal     = ctrl.illegal;
  assign instr_done  = ctrl.instr_done;
  // Debug state reads 0 while reset is held
  assign state       = rst_n ? STATE_W'(state_q) : '0;

endmodule

// File: tb/tb_mips_main_control.sv
// Self-checking bench for mips_main_control: directed scenarios plus random
// instruction streams with random memory wait states, checked every cycle
// against a table-driven model of the per-state control actions.
module tb_mips_main_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSource;
  logic [5:0] ALUOP;
  logic       illegal, instr_done;
  logic [3:0] state;

  int total = 0;
  int bad   = 0;

  logic [21:0] obs;
  logic [21:0] base_tab [16];
  int          exp_st [$];
  bit          exp_mr [$];

`ifdef MIPS_IMM_ALU_EN
  localparam bit IMM_EN = 1'b1;
`else
  localparam bit IMM_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  mips_main_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUOP(ALUOP), .illegal(illegal), .instr_done(instr_done), .state(state)
  );

  assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource,
                ALUOP, illegal, instr_done};

  function automatic logic [21:0] mk(
    input logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca,
    input logic [1:0] srcb, pcs, input logic [5:0] aop, input logic done);
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, pcs,
            aop, 1'b0, done};
  endfunction

  function automatic bit is_imm(input logic [5:0] op);
    return op == 6'h08 || op == 6'h0C || op == 6'h0D || op == 6'h0A;
  endfunction

  function automatic bit legal(input logic [5:0] op);
    return op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 ||
           op == 6'h02 || (IMM_EN && is_imm(op));
  endfunction

  // Expected control vector: state action table patched by mem_ready/opcode
  function automatic logic [21:0] expect_vec(input int st, input logic [5:0] op,
                                             input bit mr);
    logic [21:0] e;
    e = base_tab[st];
    if (st == 0 && mr) begin e[21] = 1'b1; e[16] = 1'b1; end
    if (st == 1 && !legal(op)) e[1] = 1'b1;
    if (st == 5 && mr) e[0] = 1'b1;
    if (st == 10) begin
      case (op)
        6'h0C:   e[7:2] = 6'h03;
        6'h0D:   e[7:2] = 6'h04;
        6'h0A:   e[7:2] = 6'h05;
        default: e[7:2] = 6'h00;
      endcase
    end
    return e;
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) base_tab[i] = '0;
    //                pcw pcwc iord mrd mwr irw m2r rdst rw srca srcb  pcs   aop    done
    base_tab[0]  = mk(0,  0,   0,   1,  0,  0,  0,  0,   0, 0,   2'd1, 2'd0, 6'h00, 0);
    base_tab[1]  = mk(0,  0,   0,   0,  0,  0,  0,  0,   0, 0,   2'd3, 2'd0, 6'h00, 0);
    base_tab[2]  = mk(0,  0,   0,   0,  0,  0,  0,  0,   0, 1,   2'd2, 2'd0, 6'h00, 0);
    base_tab[3]  = mk(0,  0,   1,   1,  0,  0,  0,  0,   0, 0,   2'd0, 2'd0, 6'h00, 0);
    base_tab[4]  = mk(0,  0,   0,   0,  0,  0,  1,  0,   1, 0,   2'd0, 2'd0, 6'h00, 1);
    base_tab[5]  = mk(0,  0,   1,   0,  1,  0,  0,  0,   0, 0,   2'd0, 2'd0, 6'h00, 0);
    base_tab[6]  = mk(0,  0,   0,   0,  0,  0,  0,  0,   0, 1,   2'd0, 2'd0, 6'h02, 0);
    base_tab[7]  = mk(0,  0,   0,   0,  0,  0,  0,  1,   1, 0,   2'd0, 2'd0, 6'h00, 1);
    base_tab[8]  = mk(0,  1,   0,   0,  0,  0,  0,  0,   0, 1,   2'd0, 2'd1, 6'h01, 1);
    base_tab[9]  = mk(1,  0,   0,   0,  0,  0,  0,  0,   0, 0,   2'd0, 2'd2, 6'h00, 1);
    base_tab[10] = mk(0,  0,   0,   0,  0,  0,  0,  0,   0, 1,   2'd2, 2'd0, 6'h00, 0);
    base_tab[11] = mk(0,  0,   0,   0,  0,  0,  0,  0,   1, 0,   2'd0, 2'd0, 6'h00, 1);
  end

  // Push a memory-waiting state: ws cycles with mem_ready low, then one high
  task automatic push_mem(input int st, input int ws);
    for (int k = 0; k < ws; k++) begin exp_st.push_back(st); exp_mr.push_back(1'b0); end
    exp_st.push_back(st); exp_mr.push_back(1'b1);
  endtask

  task automatic push_any(input int st);
    exp_st.push_back(st); exp_mr.push_back(1'($urandom_range(0, 1)));
  endtask

  // Expected state path of one instruction
  task automatic build(input logic [5:0] op, input int fs, input int ms);
    exp_st.delete(); exp_mr.delete();
    push_mem(0, fs);
    push_any(1);
    if (op == 6'h23) begin push_any(2); push_mem(3, ms); push_any(4); end
    else if (op == 6'h2B) begin push_any(2); push_mem(5, ms); end
    else if (op == 6'h00) begin push_any(6); push_any(7); end
    else if (op == 6'h04) push_any(8);
    else if (op == 6'h02) push_any(9);
    else if (IMM_EN && is_imm(op)) begin push_any(10); push_any(11); end
  endtask

  // Drive and check up to n cycles of the built path
  task automatic run_seq(input string name, input logic [5:0] op, input int n);
    logic [21:0] e;
    int lim;
    lim = (n < exp_st.size()) ? n : exp_st.size();
    opcode = op;
    for (int i = 0; i < lim; i++) begin
      mem_ready = exp_mr[i];
      @(negedge clk);
      total++;
      if (state !== 4'(exp_st[i])) begin
        bad++;
        $display("FAIL %s state cyc%0d op=%h: got=%0d want=%0d", name, i, op, state, exp_st[i]);
      end
      e = expect_vec(exp_st[i], op, exp_mr[i]);
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL %s ctrl cyc%0d op=%h st=%0d: got=%h want=%h", name, i, op, exp_st[i], obs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic check_zero(input string name, input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      total++;
      if (obs !== 22'h0 || state !== 4'h0) begin
        bad++;
        $display("FAIL %s cyc%0d: got ctrl=%h state=%0d want ctrl=0 state=0", name, i, obs, state);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; opcode = 6'h23; mem_ready = 1'b1;
    check_zero("reset_hold", 3);
    rst_n = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    total++;
    if (state !== 4'd0 || MemRead !== 1'b1 || IRWrite !== 1'b0 || PCWrite !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got state=%0d MemRead=%b IRWrite=%b PCWrite=%b want 0/1/0/0",
               state, MemRead, IRWrite, PCWrite);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rtype();
    build(6'h00, 0, 0); run_seq("rtype", 6'h00, 99);
  endtask

  task automatic test_lw_stall();
    build(6'h23, 0, 2); run_seq("lw_stall", 6'h23, 99);
  endtask

  task automatic test_sw_stall();
    build(6'h2B, 1, 1); run_seq("sw_stall", 6'h2B, 99);
  endtask

  task automatic test_beq();
    build(6'h04, 0, 0); run_seq("beq", 6'h04, 99);
  endtask

  task automatic test_jump();
    build(6'h02, 0, 0); run_seq("jump", 6'h02, 99);
  endtask

  task automatic test_illegal();
    build(6'h3F, 0, 0); run_seq("illegal", 6'h3F, 99);
  endtask

  task automatic test_imm();
    build(6'h08, 0, 0); run_seq("addi", 6'h08, 99);
    build(6'h0C, 0, 0); run_seq("andi", 6'h0C, 99);
    build(6'h0D, 0, 0); run_seq("ori", 6'h0D, 99);
    build(6'h0A, 0, 0); run_seq("slti", 6'h0A, 99);
  endtask

  task automatic test_reset_mid();
    build(6'h23, 0, 3); run_seq("mid_pre", 6'h23, 4);
    rst_n = 1'b0;
    check_zero("mid_reset", 2);
    rst_n = 1'b1;
    build(6'h23, 0, 0); run_seq("mid_post", 6'h23, 99);
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [9];
    logic [5:0] op;
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h0C, 6'h0D, 6'h0A};
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) < 7) op = ops[$urandom_range(0, 8)];
      else op = 6'($urandom_range(0, 63));
      build(op, $urandom_range(0, 2), $urandom_range(0, 2));
      run_seq("random", op, 99);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_stall();
    test_sw_stall();
    test_beq();
    test_jump();
    test_illegal();
    test_imm();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
